// File: rtl/cn_lane_dispatch.sv
// Job dispatcher/collector for a bank of CryptoNight hash lanes: round-robin issue of
// (state, nonce) jobs to idle lanes, round-robin collection of results into a FWFT FIFO.
module cn_lane_dispatch #(
    parameter int  NUM_LANES  = 4,
    parameter int  STATE_W    = 1600,
    parameter int  NONCE_W    = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int LANE_W     = $clog2(NUM_LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic [STATE_W-1:0]             i_state,
    input  logic [NONCE_W-1:0]             i_nonce,
    output logic                           o_ready,
    output logic [NUM_LANES-1:0]           m_valid,
    output logic [STATE_W-1:0]             m_state,
    input  logic [NUM_LANES-1:0]           m_ready,
    input  logic [NUM_LANES-1:0]           m_res_valid,
    input  logic [NUM_LANES*STATE_W-1:0]   m_res_data,
    output logic [NUM_LANES-1:0]           m_res_ready,
    output logic                           o_valid,
    output logic [STATE_W-1:0]             o_data,
    output logic [NONCE_W-1:0]             o_nonce,
    output logic [LANE_W-1:0]              o_lane,
    input  logic                           i_ready,
    output logic [NUM_LANES-1:0]           o_busy,
    output logic                           o_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_LANES-1:0] busy_reg, eligible, grant, accept_lane;
    logic [NUM_LANES-1:0] m_valid_reg;
    logic [STATE_W-1:0]   m_state_reg;
    logic [NONCE_W-1:0]   tag_reg [NUM_LANES];
    logic [STATE_W-1:0]   res_lane [NUM_LANES];
    logic [LANE_W-1:0]    disp_ptr_reg, coll_ptr_reg, disp_sel, coll_sel;
    logic [LANE_W:0]      d_idx, c_idx;
    logic                 disp_found, coll_found, accept, push, pop, full, err_reg;

    logic [STATE_W-1:0]   fifo_data  [FIFO_DEPTH];
    logic [NONCE_W-1:0]   fifo_nonce [FIFO_DEPTH];
    logic [LANE_W-1:0]    fifo_lane  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign eligible[gi]    = ~busy_reg[gi] & m_ready[gi];
            assign grant[gi]       = coll_found && (coll_sel == LANE_W'(gi));
            assign accept_lane[gi] = accept && (disp_sel == LANE_W'(gi));
            assign res_lane[gi]    = m_res_data[gi*STATE_W +: STATE_W];
        end
    endgenerate

    // Both arbiters scan NUM_LANES positions starting at their pointer, wrapping by subtraction.
    always_comb begin
        disp_found = 1'b0;
        disp_sel   = '0;
        coll_found = 1'b0;
        coll_sel   = '0;
        d_idx      = '0;
        c_idx      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            d_idx = {1'b0, disp_ptr_reg} + (LANE_W+1)'(i);
            if (d_idx >= (LANE_W+1)'(NUM_LANES))
                d_idx = d_idx - (LANE_W+1)'(NUM_LANES);
            c_idx = {1'b0, coll_ptr_reg} + (LANE_W+1)'(i);
            if (c_idx >= (LANE_W+1)'(NUM_LANES))
                c_idx = c_idx - (LANE_W+1)'(NUM_LANES);
            if (!disp_found && eligible[d_idx[LANE_W-1:0]]) begin
                disp_found = 1'b1;
                disp_sel   = d_idx[LANE_W-1:0];
            end
            if (!full && !coll_found && m_res_valid[c_idx[LANE_W-1:0]]) begin
                coll_found = 1'b1;
                coll_sel   = c_idx[LANE_W-1:0];
            end
        end
    end

    assign o_ready     = |eligible;
    assign accept      = i_valid && disp_found;
    assign push        = coll_found;
    assign pop         = o_valid && i_ready;
    assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
    assign m_res_ready = grant;
    assign m_valid     = m_valid_reg;
    assign m_state     = m_state_reg;
    assign o_busy      = busy_reg;
    assign o_err       = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg     <= '0;
            m_valid_reg  <= '0;
            m_state_reg  <= '0;
            disp_ptr_reg <= '0;
            coll_ptr_reg <= '0;
            err_reg      <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++)
                tag_reg[i] <= '0;
        end else begin
            // A result from an idle lane clears nothing; a new accept on that lane still wins.
            busy_reg    <= (busy_reg & ~grant) | accept_lane;
            m_valid_reg <= accept_lane;
            if (accept) begin
                m_state_reg  <= i_state;
                disp_ptr_reg <= (disp_sel == LANE_W'(NUM_LANES-1)) ? '0 : disp_sel + LANE_W'(1);
            end
            if (push)
                coll_ptr_reg <= (coll_sel == LANE_W'(NUM_LANES-1)) ? '0 : coll_sel + LANE_W'(1);
            for (int i = 0; i < NUM_LANES; i++)
                if (accept_lane[i])
                    tag_reg[i] <= i_nonce;
            if ((|(m_res_valid & ~busy_reg)) || (|(m_valid_reg & ~m_ready)))
                err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i]  <= '0;
                fifo_nonce[i] <= '0;
                fifo_lane[i]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr_reg]  <= res_lane[coll_sel];
                fifo_nonce[wr_ptr_reg] <= tag_reg[coll_sel];
                fifo_lane[wr_ptr_reg]  <= coll_sel;
                wr_ptr_reg             <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Head entry is read straight from the array so a push shows on o_* one cycle later.
    assign o_valid = (count_reg != '0);
    assign o_data  = fifo_data[rd_ptr_reg];
    assign o_nonce = fifo_nonce[rd_ptr_reg];
    assign o_lane  = fifo_lane[rd_ptr_reg];
endmodule

// File: tb/tb_cn_lane_dispatch.sv
// Bench for cn_lane_dispatch: directed table and corner sequences, then randomized traffic
// with emulated lanes, all checked against a queue-based reference model.
module tb_cn_lane_dispatch;
    localparam int N  = 4;
    localparam int SW = 64;
    localparam int NW = 8;
    localparam int FD = 4;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic [SW-1:0]   i_state = '0;
    logic [NW-1:0]   i_nonce = '0;
    logic            o_ready;
    logic [N-1:0]    m_valid;
    logic [SW-1:0]   m_state;
    logic [N-1:0]    m_ready = '1;
    logic [N-1:0]    m_res_valid = '0;
    logic [N*SW-1:0] m_res_data = '0;
    logic [N-1:0]    m_res_ready;
    logic            o_valid;
    logic [SW-1:0]   o_data;
    logic [NW-1:0]   o_nonce;
    logic [LW-1:0]   o_lane;
    logic            i_ready = 1'b0;
    logic [N-1:0]    o_busy;
    logic            o_err;

    always #5 clk = ~clk;

    cn_lane_dispatch #(.NUM_LANES(N), .STATE_W(SW), .NONCE_W(NW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_state(i_state), .i_nonce(i_nonce),
        .o_ready(o_ready), .m_valid(m_valid), .m_state(m_state), .m_ready(m_ready),
        .m_res_valid(m_res_valid), .m_res_data(m_res_data), .m_res_ready(m_res_ready),
        .o_valid(o_valid), .o_data(o_data), .o_nonce(o_nonce), .o_lane(o_lane),
        .i_ready(i_ready), .o_busy(o_busy), .o_err(o_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: per-lane busy/tag, two pointers, result queue.
    typedef struct { logic [SW-1:0] d; logic [NW-1:0] n; int l; } ent_t;
    ent_t          q[$];
    bit            mb[N];
    logic [NW-1:0] mt[N];
    int            dptr, cptr;
    logic [N-1:0]  mmv;
    logic [SW-1:0] mms;
    bit            merr;

    // Lane emulation state for the random phase.
    logic [N-1:0]  last_grant, last_mv;
    logic [SW-1:0] last_ms;
    bit            lane_act[N];
    int            lane_t[N];
    logic [SW-1:0] lane_s[N];

    function automatic void model_reset();
        q.delete();
        for (int k = 0; k < N; k++) begin
            mb[k] = 0; mt[k] = '0; lane_act[k] = 0; lane_t[k] = 0; lane_s[k] = '0;
        end
        dptr = 0; cptr = 0; mmv = '0; mms = '0; merr = 0;
        last_grant = '0; last_mv = '0; last_ms = '0;
    endfunction

    function automatic int pick(input int ptr, input logic [N-1:0] req);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_res(input int k, input logic [SW-1:0] v);
        m_res_valid[k] = 1'b1;
        m_res_data[k*SW +: SW] = v;
    endtask

    // One clock: compare DUT with the model, advance the model, lanes drop granted results.
    task automatic cycle();
        logic [N-1:0] e, eg, bv, one;
        int d, g;
        ent_t ent;
        one = 1;
        #1;
        for (int k = 0; k < N; k++) begin
            e[k]  = !mb[k] && m_ready[k];
            bv[k] = mb[k];
        end
        d  = pick(dptr, e);
        g  = (q.size() < FD) ? pick(cptr, m_res_valid) : -1;
        eg = (g >= 0) ? (one << g) : '0;
        chk("o_ready", o_ready, d >= 0);
        chk("m_res_ready", m_res_ready, eg);
        chk("m_valid", m_valid, mmv);
        if (mmv != '0) chk("m_state", m_state, mms);
        chk("o_busy", o_busy, bv);
        chk("o_err", o_err, merr);
        chk("o_valid", o_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("o_data", o_data, q[0].d);
            chk("o_nonce", o_nonce, q[0].n);
            chk("o_lane", o_lane, q[0].l);
        end
        last_grant = m_res_ready;
        last_mv    = m_valid;
        last_ms    = m_state;
        for (int k = 0; k < N; k++)
            if ((m_res_valid[k] && !mb[k]) || (mmv[k] && !m_ready[k])) merr = 1;
        if (q.size() != 0 && i_ready) void'(q.pop_front());
        if (g >= 0) begin
            ent.d = m_res_data[g*SW +: SW]; ent.n = mt[g]; ent.l = g;
            q.push_back(ent);
            mb[g] = 0;
            cptr = (g + 1) % N;
        end
        if (i_valid && d >= 0) begin
            mt[d] = i_nonce; mb[d] = 1; dptr = (d + 1) % N;
            mmv = one << d; mms = i_state;
        end else begin
            mmv = '0;
        end
        @(posedge clk);
        @(negedge clk);
        m_res_valid = m_res_valid & ~eg;
        $display("cycle t=%0t iv=%b rdy=%b mv=%b grant=%b ov=%b nonce=%0h lane=%0d busy=%b err=%b",
                 $time, i_valid, d >= 0, mmv, eg, q.size() != 0, o_nonce, o_lane, o_busy, o_err);
    endtask

    task automatic lanes_step();
        for (int k = 0; k < N; k++) begin
            if (last_grant[k]) lane_act[k] = 0;
            if (lane_act[k] && !m_res_valid[k]) begin
                if (lane_t[k] == 0) set_res(k, lane_s[k] ^ {32'(k + 1), 32'h5A5A_0000});
                else lane_t[k]--;
            end
            if (last_mv[k]) begin
                lane_act[k] = 1; lane_t[k] = $urandom_range(0, 5); lane_s[k] = last_ms;
            end
            m_ready[k] = !lane_act[k] && (m_valid[k] || ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 0; i_ready = 0; m_ready = '1; m_res_valid = '0; m_res_data = '0;
        i_state = '0; i_nonce = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic iv; logic [NW-1:0] nonce; logic exp_ready; logic [N-1:0] exp_mv; logic [N-1:0] exp_busy;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 8'h10, 1'b1, 4'b0000, 4'b0000};
        tbl[1] = '{1'b1, 8'h11, 1'b1, 4'b0001, 4'b0001};
        tbl[2] = '{1'b1, 8'h12, 1'b1, 4'b0010, 4'b0011};
        tbl[3] = '{1'b1, 8'h13, 1'b1, 4'b0100, 4'b0111};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 4'b1000, 4'b1111};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 4'b0000, 4'b1111};

        do_reset();
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_lane", o_lane, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_o_busy", o_busy, 0);

        // Four back-to-back jobs fill the lanes in order.
        for (int i = 0; i < 6; i++) begin
            i_valid = tbl[i].iv;
            i_nonce = tbl[i].nonce;
            i_state = {56'hC0FFEE_0000_0000, tbl[i].nonce};
            #1;
            chk("tbl_o_ready", o_ready, tbl[i].exp_ready);
            chk("tbl_m_valid", m_valid, tbl[i].exp_mv);
            chk("tbl_o_busy", o_busy, tbl[i].exp_busy);
            cycle();
        end

        // Lanes 2 and 0 finish together; lane 0 wins.
        i_ready = 1;
        set_res(0, 64'hD000_0000_0000_0000);
        set_res(2, 64'hD222_0000_0000_0002);
        #1 chk("t2_grant0", m_res_ready, 4'b0001);
        cycle();
        #1 chk("t2_grant2", m_res_ready, 4'b0100);
        chk("t2_nonce10", o_nonce, 8'h10);
        cycle();
        #1 chk("t2_nonce12", o_nonce, 8'h12);
        chk("t2_busy", o_busy, 4'b1010);
        cycle();

        // Full FIFO holds back the fifth result until a pop frees a slot.
        i_ready = 0;
        i_valid = 1; i_nonce = 8'h20; i_state = 64'h20; cycle();
        i_nonce = 8'h21; i_state = 64'h21; cycle();
        i_valid = 0;
        for (int k = 0; k < N; k++) set_res(k, 64'hA000 + 64'(k));
        repeat (4) cycle();
        i_valid = 1; i_nonce = 8'h30; i_state = 64'h30; cycle();
        i_valid = 0; cycle();
        set_res(3, 64'hB003);
        #1 chk("t3_full_hold", m_res_ready, 4'b0000);
        chk("t3_full_valid", o_valid, 1);
        cycle(); cycle();
        i_ready = 1;
        #1 chk("t3_pop_no_grant", m_res_ready, 4'b0000);
        cycle();
        i_ready = 0;
        #1 chk("t3_push_after_pop", m_res_ready, 4'b1000);
        cycle();
        i_ready = 1;
        repeat (6) cycle();

        // A lane freed by a grant takes the very next job.
        for (int j = 0; j < 4; j++) begin
            i_valid = 1; i_nonce = 8'h40 + 8'(j); i_state = 64'h4000 + 64'(j); cycle();
        end
        i_valid = 0; cycle();
        set_res(1, 64'hC001);
        #1 chk("t4_grant1", m_res_ready, 4'b0010);
        chk("t4_ready_before", o_ready, 0);
        cycle();
        i_valid = 1; i_nonce = 8'h44; i_state = 64'h4444;
        #1 chk("t4_ready", o_ready, 1);
        cycle();
        i_valid = 0;
        #1 chk("t4_m_valid", m_valid, 4'b0010);
        cycle();

        // A result from an idle lane raises the sticky error but is still queued.
        set_res(3, 64'hE003);
        #1 chk("t5_grant3", m_res_ready, 4'b1000);
        cycle();
        set_res(3, 64'hEBAD);
        #1 chk("t5_err_before", o_err, 0);
        cycle();
        #1 chk("t5_err", o_err, 1);
        chk("t5_lane", o_lane, 3);
        chk("t5_data", o_data, 64'hEBAD);
        repeat (3) cycle();
        #1 chk("t5_err_held", o_err, 1);

        // Reset mid-operation with three busy lanes and two queued results.
        i_ready = 0;
        set_res(0, 64'hF000); set_res(1, 64'hF001);
        cycle(); cycle();
        i_valid = 1; i_nonce = 8'h60; cycle();
        i_nonce = 8'h61; cycle();
        i_valid = 0;
        #1 chk("t6_pre_busy", o_busy, 4'b1101);
        #1 rst = 1'b1;
        #1;
        chk("t6_o_valid", o_valid, 0);
        chk("t6_o_busy", o_busy, 0);
        chk("t6_o_err", o_err, 0);
        @(negedge clk);
        m_res_valid = '0; m_ready = '1;
        rst = 1'b0;
        model_reset();
        i_valid = 1; i_nonce = 8'h70; i_state = 64'h7070;
        cycle();
        i_valid = 0;
        #1 chk("t6_first_lane0", m_valid, 4'b0001);
        m_ready = 4'b1110;
        cycle();
        m_ready = 4'b1111;
        #1 chk("err_mready_drop", o_err, 1);
        cycle();

        // Randomized traffic with well-behaved lanes.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            lanes_step();
            i_valid = ($urandom_range(0, 2) != 0);
            i_nonce = NW'($urandom);
            i_state = {$urandom, $urandom};
            i_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
